// File: rtl/multi_timer.sv
// multi_timer: CHANNELS independent prescaled up/down tick counters with one-shot or auto-reload.
module multi_timer #(
  parameter int WIDTH     = 32,
  parameter int PRE_WIDTH = 32,
  parameter int CHANNELS  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [PRE_WIDTH-1:0]      divisor_i,
  input  logic [CHANNELS-1:0]       enable_i,
  input  logic [CHANNELS-1:0]       clear_i,
  input  logic [CHANNELS-1:0]       down_i,
  input  logic [CHANNELS-1:0]       reload_i,
  input  logic [CHANNELS*WIDTH-1:0] limit_i,
  output logic [CHANNELS*WIDTH-1:0] count_o,
  output logic [CHANNELS-1:0]       done_o,
  output logic [CHANNELS-1:0]       expire_o
);
  typedef enum logic [1:0] {IDLE, RUN, HELD} state_e;
  logic [PRE_WIDTH-1:0] last_pre;
  // A divisor of 0 behaves as 1, so the last prescaler value is 0 in both cases.
  assign last_pre = (divisor_i == '0) ? '0 : divisor_i - PRE_WIDTH'(1);
  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      state_e               state_q, state_d;
      logic [PRE_WIDTH-1:0] pre_q, pre_d;
      logic [WIDTH-1:0]     count_q, count_d, lim, start, term_v;
      logic [WIDTH:0]       nxt;
      logic                 done_q, done_d, expire_q, expire_d, step, term;
      assign lim    = limit_i[c*WIDTH +: WIDTH];
      assign start  = down_i[c] ? lim : '0;
      assign term_v = down_i[c] ? '0 : lim;
      // Extra bit keeps the up-mode compare saturating instead of wrapping.
      assign nxt    = {1'b0, count_q} + (WIDTH+1)'(1);
      assign step   = enable_i[c] && state_q != HELD && pre_q >= last_pre;
      assign term   = down_i[c] ? (count_q <= WIDTH'(1)) : (nxt >= {1'b0, lim});
      always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        count_d  = count_q;
        done_d   = done_q;
        expire_d = 1'b0;
        if (clear_i[c]) begin
          state_d = IDLE;
          pre_d   = '0;
          count_d = start;
          done_d  = 1'b0;
        end else if (state_q == HELD) begin
          pre_d = '0;
        end else if (!enable_i[c]) begin
          state_d = IDLE;
          pre_d   = '0;
        end else begin
          state_d = RUN;
          pre_d   = step ? '0 : pre_q + PRE_WIDTH'(1);
          if (step && !term) count_d = down_i[c] ? count_q - WIDTH'(1) : nxt[WIDTH-1:0];
          if (step && term) begin
            done_d   = 1'b1;
            expire_d = 1'b1;
            count_d  = reload_i[c] ? start : term_v;
            state_d  = reload_i[c] ? RUN : HELD;
          end
        end
      end
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          state_q  <= IDLE;
          pre_q    <= '0;
          count_q  <= '0;
          done_q   <= 1'b0;
          expire_q <= 1'b0;
        end else begin
          state_q  <= state_d;
          pre_q    <= pre_d;
          count_q  <= count_d;
          done_q   <= done_d;
          expire_q <= expire_d;
        end
      end
      assign count_o[c*WIDTH +: WIDTH] = count_q;
      assign done_o[c]   = done_q;
      assign expire_o[c] = expire_q;
    end
  endgenerate
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed test-plan scenarios plus randomized traffic against a tick-level reference model.
module tb_multi_timer;
  localparam int W = 8, PW = 8, CH = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [PW-1:0] div = '0;
  logic [CH-1:0] en = '0, clr = '0, dn = '0, rl = '0;
  logic [CH*W-1:0] lim = '0;
  logic [CH*W-1:0] cnt;
  logic [CH-1:0] done, expo;
  int n_checks = 0, n_errors = 0;
  int m_cnt[CH], m_win[CH];
  bit m_done[CH], m_held[CH], m_exp[CH];

  always #5 clk = ~clk;

  multi_timer #(.WIDTH(W), .PRE_WIDTH(PW), .CHANNELS(CH)) dut (
    .clk_i(clk), .rst_i(rst), .divisor_i(div), .enable_i(en), .clear_i(clr),
    .down_i(dn), .reload_i(rl), .limit_i(lim), .count_o(cnt), .done_o(done), .expire_o(expo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < CH; ch++) begin
      m_cnt[ch] = 0; m_win[ch] = 0; m_done[ch] = 0; m_held[ch] = 0; m_exp[ch] = 0;
    end
  endtask

  // One rising edge: a tick happens once D enabled cycles have accumulated in the window.
  task automatic model_edge();
    int d, l, s;
    d = (div == 0) ? 1 : int'(div);
    for (int ch = 0; ch < CH; ch++) begin
      l = int'(lim[ch*W +: W]);
      s = dn[ch] ? l : 0;
      m_exp[ch] = 0;
      if (clr[ch]) begin
        m_cnt[ch] = s; m_win[ch] = 0; m_done[ch] = 0; m_held[ch] = 0;
      end else if (m_held[ch] || !en[ch]) begin
        m_win[ch] = 0;
      end else begin
        m_win[ch]++;
        if (m_win[ch] >= d) begin
          m_win[ch] = 0;
          if (dn[ch] ? (m_cnt[ch] > 1) : (m_cnt[ch] + 1 < l)) begin
            m_cnt[ch] = dn[ch] ? m_cnt[ch] - 1 : m_cnt[ch] + 1;
          end else begin
            m_done[ch] = 1; m_exp[ch] = 1;
            if (rl[ch]) m_cnt[ch] = s;
            else begin m_cnt[ch] = dn[ch] ? 0 : l; m_held[ch] = 1; end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int ch = 0; ch < CH; ch++) begin
      check($sformatf("count%0d", ch), cnt[ch*W +: W], m_cnt[ch]);
      check($sformatf("done%0d", ch), done[ch], m_done[ch]);
      check($sformatf("expire%0d", ch), expo[ch], m_exp[ch]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_ch(input int ch, input bit e, input bit c, input bit d, input bit r, input int l);
    en[ch] = e; clr[ch] = c; dn[ch] = d; rl[ch] = r; lim[ch*W +: W] = W'(l);
  endtask

  initial begin
    int nexp;
    model_reset();
    #3;
    compare_all();
    #9 rst = 1'b0;
    // Up one-shot, divisor 4, limit 3.
    div = 4; set_ch(0, 1, 0, 0, 0, 3);
    nexp = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      nexp += int'(expo[0]);
      if (i == 4) check("tp1_edge4", cnt[W-1:0], 1);
      if (i == 8) check("tp1_edge8", cnt[W-1:0], 2);
      if (i == 12) check("tp1_edge12", cnt[W-1:0], 3);
    end
    check("tp1_expire_count", nexp, 1);
    check("tp1_hold", cnt[W-1:0], 3);
    // Down reload, divisor 2, limit 3.
    div = 2; set_ch(0, 0, 1, 1, 1, 3);
    tick();
    check("tp2_clear_load", cnt[W-1:0], 3);
    set_ch(0, 1, 0, 1, 1, 3);
    nexp = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      nexp += int'(expo[0]);
      if (i == 2) check("tp2_step1", cnt[W-1:0], 2);
      if (i == 4) check("tp2_step2", cnt[W-1:0], 1);
      if (i == 6) check("tp2_wrap", cnt[W-1:0], 3);
    end
    check("tp2_expire_count", nexp, 2);
    // Pause restarts the prescaler window.
    div = 5; set_ch(0, 0, 1, 0, 0, 10);
    tick();
    set_ch(0, 1, 0, 0, 0, 10);
    repeat (3) tick();
    en[0] = 0; tick();
    en[0] = 1; repeat (4) tick();
    check("tp3_no_step", cnt[W-1:0], 0);
    tick();
    check("tp3_step", cnt[W-1:0], 1);
    // Clear colliding with a terminal step.
    div = 1; set_ch(0, 0, 1, 0, 0, 2);
    tick();
    set_ch(0, 1, 0, 0, 0, 2);
    tick();
    clr[0] = 1; tick();
    check("tp4_no_expire", expo[0], 0);
    check("tp4_done_low", done[0], 0);
    check("tp4_start", cnt[W-1:0], 0);
    clr[0] = 0; repeat (3) tick();
    check("tp4_done_later", done[0], 1);
    // Asynchronous reset between edges.
    div = 3; set_ch(0, 0, 1, 0, 0, 200);
    tick();
    set_ch(0, 1, 0, 0, 0, 200);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("tp5_rst_count", cnt, 0);
    check("tp5_rst_done", done, 0);
    check("tp5_rst_expire", expo, 0);
    model_reset();
    #3 rst = 1'b0;
    repeat (2) tick();
    check("tp5_wait", cnt[W-1:0], 0);
    tick();
    check("tp5_first_step", cnt[W-1:0], 1);
    // Two independent channels at divisor 1.
    div = 1; set_ch(0, 0, 1, 0, 0, 2); set_ch(1, 0, 1, 1, 1, 0);
    tick();
    set_ch(0, 1, 0, 0, 0, 2); set_ch(1, 1, 0, 1, 1, 0);
    nexp = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      nexp += int'(expo[1]);
      if (i == 1) check("tp6_ch0_notdone", done[0], 0);
      if (i == 2) check("tp6_ch0_done", done[0], 1);
    end
    check("tp6_ch1_expires", nexp, 6);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) div = PW'($urandom_range(0, 4));
      for (int ch = 0; ch < CH; ch++) begin
        en[ch] = ($urandom_range(0, 7) != 0);
        clr[ch] = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 31) == 0) dn[ch] = ~dn[ch];
        if ($urandom_range(0, 31) == 0) rl[ch] = ~rl[ch];
        if ($urandom_range(0, 15) == 0) lim[ch*W +: W] = W'($urandom_range(0, 6));
      end
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
